fsoc_gpio: RTL and testbench
============================

// Module: fsoc_gpio
// PURPOSE
//   Parametrised GPIO peripheral for the fsoc SoC on the FABulous fabric. It replaces the fixed
//   8-bit gpo / 1-bit gpi pins with GPIOCNT bidirectional pins.
//   - Per-pin output enable, driving the fabric io_oeb convention (0 = driven).
//   - Synchronised inputs with rising/falling edge capture into a pending register.
//   - One level interrupt line.
//   - Accessed over a Wishbone-classic slave port.
// PARAMETERS
//   GPIOCNT      8    number of pins, 1..32
//   SYNC_STAGES  2    input synchroniser depth, 2..4
//   RST_OUT      '0   reset value of OUT[GPIOCNT-1:0]
//   RST_OEN      '0   reset value of OEN[GPIOCNT-1:0] (1 = pin driven)
// PORTS
//   clk_i      in   1        system clock
//   rst_in     in   1        synchronous reset, active low
//   wb_cyc_i   in   1        bus cycle
//   wb_stb_i   in   1        strobe
//   wb_we_i    in   1        1 = write
//   wb_adr_i   in   3        word index into register map
//   wb_dat_i   in   32       write data
//   wb_dat_o   out  32       read data, valid with wb_ack_o
//   wb_ack_o   out  1        single-cycle acknowledge
//   gpio_i     in   GPIOCNT  asynchronous pad inputs
//   gpio_o     out  GPIOCNT  pad outputs (= OUT)
//   gpio_oeb   out  GPIOCNT  pad output-enable, active low (= ~OEN)
//   irq_o      out  1        registered interrupt, |(PEND & IEN)
// BEHAVIOUR
//   Register map (word index):
//     0 OUT   rw
//     1 OEN   rw
//     2 IN    ro (synchronised pins)
//     3 IEN   rw
//     4 RISE  rw (edge select)
//     5 FALL  rw (edge select)
//     6 PEND  rw1c
//     7 TGL   wo (OUT ^= wdata; reads 0)
//   Reset (rst_in=0 at a clk_i edge, any cycle):
//     - OUT=RST_OUT, OEN=RST_OEN; IEN/RISE/FALL/PEND=0.
//     - Synchroniser and edge-history flops = 0.
//     - wb_ack_o=0, wb_dat_o=0, irq_o=0.
//     - Any bus access in flight is dropped with no ack.
//   Bus:
//     - Request = cyc & stb & !ack. wb_ack_o rises the edge after a request and is high exactly one
//       cycle, so back-to-back accesses take 2 cycles each.
//     - Writes commit at the edge that raises ack.
//     - wb_dat_o = selected register while ack, else 0.
//     - Bits [31:GPIOCNT] read 0; writes to them are ignored; writes to IN are ignored.
//     - Dropping stb before ack cancels the access with no side effects.
//   Input path:
//     - gpio_i passes through SYNC_STAGES flops -> IN.
//     - A pin change is visible in IN after SYNC_STAGES edges.
//     - prev <= IN each cycle. rise = IN & ~prev & RISE; fall = ~IN & prev & FALL.
//   Edge blanking:
//     - A counter suppresses edge capture for the first SYNC_STAGES+1 cycles after reset release.
//     - This means pins high at reset generate no rising edge.
//   PEND:
//     - PEND |= rise | fall, regardless of IEN.
//     - A W1C write on the same cycle as a new edge on the same bit leaves that bit set (set wins).
//   irq_o:
//     - Registered: irq_o(t+1) = |(PEND(t) & IEN(t)).
//     - Latency from a pad edge to irq_o is SYNC_STAGES+3 edges: SYNC_STAGES to reach IN, +1 to set
//       PEND, +1 to register irq_o, +1 for the edge-capture stage on IN.
//   TGL:
//     - A write XORs wdata into OUT.
//     - TGL and OUT are distinct addresses, so no same-cycle conflict is possible.
//   Outputs:
//     - gpio_o and gpio_oeb are direct from registers, with no extra delay after the commit edge.
// TESTING
//   1. Reset, GPIOCNT=8, RST_OEN=8'h0F -> gpio_oeb=8'hF0, gpio_o=0, irq_o=0; read OEN=32'h0F.
//   2. Write OUT=32'hFFFF_FFA5, then TGL=32'h0F -> gpio_o=8'hAA; read OUT=32'hAA; ack exactly 1 cycle.
//   3. RISE=1, IEN=1, gpio_i[0] 0->1 -> PEND=1 and irq_o=1 after 5 edges (SYNC_STAGES=2);
//      write PEND=1 -> irq_o=0 two edges later.
//   4. gpio_i=8'hFF held through reset with RISE=FALL=8'hFF -> PEND stays 0 after release.
//   5. W1C of PEND[3] on the same cycle FALL edge on pin 3 is captured -> PEND[3]=1.
//   6. rst_in asserted while stb is pending -> no ack, all registers at reset values next cycle.

Source files
------------

// File: rtl/fsoc_gpio.sv
// fsoc_gpio: parametrised bidirectional GPIO block with per-pin output enable,
// synchronised inputs, edge capture into a pending register, a level
// interrupt and a Wishbone-classic slave port.
//
// Bus handshake: a request is cyc & stb & !ack. The request is accepted at the
// next clk_i edge, and wb_ack_o is high for exactly the following cycle.
// Writes commit at that same edge. Read data is captured at that edge and is
// presented on wb_dat_o only while wb_ack_o is high; otherwise wb_dat_o is 0.
// Because ack masks the request, each access takes two cycles back-to-back.
module fsoc_gpio #(
    parameter int               GPIOCNT     = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [GPIOCNT-1:0] RST_OUT   = '0,
    parameter logic [GPIOCNT-1:0] RST_OEN   = '0
) (
    input  logic               clk_i,
    input  logic               rst_in,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [2:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    input  logic [GPIOCNT-1:0] gpio_i,
    output logic [GPIOCNT-1:0] gpio_o,
    output logic [GPIOCNT-1:0] gpio_oeb,
    output logic               irq_o
);

    localparam int CW = $clog2(SYNC_STAGES + 2);

    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_OEN  = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_IEN  = 3'd3;
    localparam logic [2:0] A_RISE = 3'd4;
    localparam logic [2:0] A_FALL = 3'd5;
    localparam logic [2:0] A_PEND = 3'd6;
    localparam logic [2:0] A_TGL  = 3'd7;

    logic [GPIOCNT-1:0] r_out, r_oen, r_ien, r_rise, r_fall, r_pend;
    logic [GPIOCNT-1:0] r_sync [SYNC_STAGES];
    logic [GPIOCNT-1:0] r_prev;
    logic [GPIOCNT-1:0] r_edge;
    logic [CW-1:0]      r_blank_cnt;
    logic               r_ack;
    logic               r_irq;
    logic [31:0]        r_dat;

    logic               w_req;
    logic               w_wr;
    logic               w_blank;
    logic [GPIOCNT-1:0] w_in;
    logic [GPIOCNT-1:0] w_wdat;
    logic [GPIOCNT-1:0] w_pend_clr;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr     = w_req & wb_we_i;
    assign w_in     = r_sync[SYNC_STAGES-1];
    assign w_wdat   = wb_dat_i[GPIOCNT-1:0];
    // Edge capture stays off until the synchroniser and prev flops have
    // filled with real pad values, so pins already high at reset stay quiet.
    assign w_blank  = (r_blank_cnt <= CW'(SYNC_STAGES));
    assign w_pend_clr = (w_wr && (wb_adr_i == A_PEND)) ? w_wdat : '0;
    // Upper write-data bits beyond GPIOCNT are intentionally ignored.
    assign w_unused = ^wb_dat_i;

    // Input synchroniser chain: pad -> r_sync[0] -> ... -> IN.
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    // Post-reset blanking counter, saturates once capture is enabled.
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            r_blank_cnt <= '0;
        end else if (w_blank) begin
            r_blank_cnt <= r_blank_cnt + 1'b1;
        end
    end

    // Edge detection on IN, registered before it reaches PEND.
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            r_prev <= '0;
            r_edge <= '0;
        end else begin
            r_prev <= w_in;
            r_edge <= w_blank ? '0
                    : ((w_in & ~r_prev & r_rise) | (~w_in & r_prev & r_fall));
        end
    end

    // Control registers and pending bits; a new edge wins over a W1C clear.
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            r_out  <= RST_OUT;
            r_oen  <= RST_OEN;
            r_ien  <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_pend_clr) | r_edge;
            if (w_wr) begin
                case (wb_adr_i)
                    A_OUT:   r_out  <= w_wdat;
                    A_OEN:   r_oen  <= w_wdat;
                    A_IEN:   r_ien  <= w_wdat;
                    A_RISE:  r_rise <= w_wdat;
                    A_FALL:  r_fall <= w_wdat;
                    A_TGL:   r_out  <= r_out ^ w_wdat;
                    default: ;
                endcase
            end
        end
    end

    // Read multiplexer; unimplemented upper bits and TGL read as zero.
    always_comb begin
        w_rdata = '0;
        case (wb_adr_i)
            A_OUT:   w_rdata[GPIOCNT-1:0] = r_out;
            A_OEN:   w_rdata[GPIOCNT-1:0] = r_oen;
            A_IN:    w_rdata[GPIOCNT-1:0] = w_in;
            A_IEN:   w_rdata[GPIOCNT-1:0] = r_ien;
            A_RISE:  w_rdata[GPIOCNT-1:0] = r_rise;
            A_FALL:  w_rdata[GPIOCNT-1:0] = r_fall;
            A_PEND:  w_rdata[GPIOCNT-1:0] = r_pend;
            default: w_rdata = '0;
        endcase
    end

    // Bus acknowledge, read data capture and registered interrupt.
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_irq <= 1'b0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wb_we_i) ? w_rdata : '0;
            r_irq <= |(r_pend & r_ien);
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign gpio_o   = r_out;
    assign gpio_oeb = ~r_oen;
    assign irq_o    = r_irq;

endmodule

// File: tb/tb_fsoc_gpio.sv
// Bench for fsoc_gpio: directed bus and pad stimulus, an edge-indexed
// behavioural model checked every cycle, plus literal spot checks.
module tb_fsoc_gpio;

    localparam int G  = 8;
    localparam int SS = 2;

    logic          clk_i = 1'b0;
    logic          rst_in;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [2:0]    wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic [G-1:0]  gpio_i, gpio_o, gpio_oeb;
    logic          irq_o;

    int errs = 0;
    int chks = 0;
    bit checking = 1'b0;

    fsoc_gpio #(
        .GPIOCNT(G), .SYNC_STAGES(SS), .RST_OUT(8'h00), .RST_OEN(8'h0F)
    ) dut (
        .clk_i(clk_i), .rst_in(rst_in),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .gpio_i(gpio_i), .gpio_o(gpio_o),
        .gpio_oeb(gpio_oeb), .irq_o(irq_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // IN is the pad sample taken SS-1 edges before the latest edge; a change
    // on IN between two consecutive edges lands in PEND two edges later,
    // unless it falls inside the post-reset blanking window.
    logic [G-1:0] m_out, m_oen, m_ien, m_rise, m_fall, m_pend;
    logic [G-1:0] m_rise_d, m_fall_d;
    logic         m_ack, m_irq;
    logic [31:0]  m_dat;
    logic [G-1:0] pad_q[$];
    logic [G-1:0] in_q[$];
    int           n_edges;
    logic         mv_req;
    logic [G-1:0] mv_set, mv_clr, mv_wd;

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            3'd0: v[G-1:0] = m_out;
            3'd1: v[G-1:0] = m_oen;
            3'd2: v[G-1:0] = in_q[0];
            3'd3: v[G-1:0] = m_ien;
            3'd4: v[G-1:0] = m_rise;
            3'd5: v[G-1:0] = m_fall;
            3'd6: v[G-1:0] = m_pend;
            default: v = '0;
        endcase
        return v;
    endfunction

    always @(posedge clk_i) begin
        if (!rst_in) begin
            m_out <= 8'h00; m_oen <= 8'h0F; m_ien <= '0; m_rise <= '0;
            m_fall <= '0; m_pend <= '0; m_rise_d <= '0; m_fall_d <= '0;
            m_ack <= 1'b0; m_dat <= '0; m_irq <= 1'b0;
            n_edges <= 0;
            pad_q.delete();
            in_q.delete();
            for (int i = 0; i < 3; i++) in_q.push_back('0);
        end else begin
            mv_req = wb_cyc_i & wb_stb_i & ~m_ack;
            mv_wd  = wb_dat_i[G-1:0];
            mv_set = '0;
            if (n_edges >= SS + 2)
                mv_set = (in_q[1] & ~in_q[2] & m_rise_d) | (~in_q[1] & in_q[2] & m_fall_d);
            mv_clr = (mv_req && wb_we_i && wb_adr_i == 3'd6) ? mv_wd : '0;
            m_rise_d <= m_rise;
            m_fall_d <= m_fall;
            m_irq    <= |(m_pend & m_ien);
            m_ack    <= mv_req;
            m_dat    <= (mv_req && !wb_we_i) ? m_read(wb_adr_i) : 32'h0;
            m_pend   <= (m_pend & ~mv_clr) | mv_set;
            if (mv_req && wb_we_i) begin
                case (wb_adr_i)
                    3'd0: m_out  <= mv_wd;
                    3'd1: m_oen  <= mv_wd;
                    3'd3: m_ien  <= mv_wd;
                    3'd4: m_rise <= mv_wd;
                    3'd5: m_fall <= mv_wd;
                    3'd7: m_out  <= m_out ^ mv_wd;
                    default: ;
                endcase
            end
            pad_q.push_front(gpio_i);
            while (pad_q.size() > SS) void'(pad_q.pop_back());
            in_q.push_front((pad_q.size() >= SS) ? pad_q[SS-1] : '0);
            while (in_q.size() > 3) void'(in_q.pop_back());
            n_edges <= n_edges + 1;
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk_i) begin
        if (checking) begin
            check("cyc_gpio_o",   {24'h0, gpio_o},   {24'h0, m_out});
            check("cyc_gpio_oeb", {24'h0, gpio_oeb}, {24'h0, ~m_oen});
            check("cyc_irq",      {31'h0, irq_o},    {31'h0, m_irq});
            check("cyc_ack",      {31'h0, wb_ack_o}, {31'h0, m_ack});
            check("cyc_dat",      wb_dat_o,          m_dat);
        end
    end

    // ---------------- driver tasks (called and return at a negedge) ----------------
    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = a; wb_dat_i = d;
        @(negedge clk_i);
        check("wr_ack_hi", {31'h0, wb_ack_o}, 32'h1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = '0;
        @(negedge clk_i);
        check("wr_ack_lo", {31'h0, wb_ack_o}, 32'h0);
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
        @(negedge clk_i);
        check("rd_ack_hi", {31'h0, wb_ack_o}, 32'h1);
        d = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk_i);
        check("rd_ack_lo", {31'h0, wb_ack_o}, 32'h0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errs + 1, chks + 1);
        $fatal(1, "timeout");
    end

    logic [31:0] rd;

    initial begin
        rst_in = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; gpio_i = '0;
        repeat (3) @(negedge clk_i);
        checking = 1'b1;

        // 1: reset values
        check("rst_oeb", {24'h0, gpio_oeb}, 32'h0000_00F0);
        check("rst_out", {24'h0, gpio_o},   32'h0);
        check("rst_irq", {31'h0, irq_o},    32'h0);
        rst_in = 1'b1;
        @(negedge clk_i);
        wb_read(3'd1, rd); check("rd_oen", rd, 32'h0000_000F);

        // 2: OUT write with upper bits, toggle, readback
        wb_write(3'd0, 32'hFFFF_FFA5);
        check("out_a5", {24'h0, gpio_o}, 32'h0000_00A5);
        wb_write(3'd7, 32'h0000_000F);
        check("tgl_aa", {24'h0, gpio_o}, 32'h0000_00AA);
        wb_read(3'd0, rd); check("rd_out", rd, 32'h0000_00AA);
        wb_read(3'd7, rd); check("rd_tgl", rd, 32'h0);
        wb_write(3'd2, 32'hFFFF_FFFF);
        wb_read(3'd2, rd); check("rd_in_ro", rd, 32'h0);
        wb_write(3'd1, 32'h0000_0133);
        check("oen_33", {24'h0, gpio_oeb}, 32'h0000_00CC);

        // 3: rising edge on pin 0 -> irq after 5 edges, then W1C
        wb_write(3'd4, 32'h1);
        wb_write(3'd3, 32'h1);
        gpio_i[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            if (k == 4) check("irq_lat4", {31'h0, irq_o}, 32'h0);
            if (k == 5) check("irq_lat5", {31'h0, irq_o}, 32'h1);
        end
        wb_read(3'd6, rd); check("pend_r0", rd, 32'h1);
        wb_write(3'd6, 32'h1);
        check("irq_clr", {31'h0, irq_o}, 32'h0);
        wb_read(3'd6, rd); check("pend_clr", rd, 32'h0);
        gpio_i[0] = 1'b0;
        repeat (8) @(negedge clk_i);
        wb_read(3'd6, rd); check("fall_unsel", rd, 32'h0);

        // 4: pins high through reset produce no edge
        gpio_i = 8'hFF;
        rst_in = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_in = 1'b1;
        wb_write(3'd4, 32'hFF);
        wb_write(3'd5, 32'hFF);
        wb_write(3'd3, 32'hFF);
        repeat (8) @(negedge clk_i);
        wb_read(3'd6, rd); check("blank_pend", rd, 32'h0);
        check("blank_irq", {31'h0, irq_o}, 32'h0);
        wb_read(3'd2, rd); check("rd_in_ff", rd, 32'h0000_00FF);

        // 5: W1C coincident with a fall capture on pin 3 -> set wins
        gpio_i[3] = 1'b0;
        repeat (6) @(negedge clk_i);
        wb_read(3'd6, rd); check("pend_fall3", rd, 32'h08);
        check("irq_fall3", {31'h0, irq_o}, 32'h1);
        gpio_i[3] = 1'b1;
        repeat (6) @(negedge clk_i);
        gpio_i[3] = 1'b0;
        repeat (3) @(negedge clk_i);
        wb_write(3'd6, 32'h08);
        wb_read(3'd6, rd); check("set_wins", rd, 32'h08);
        wb_write(3'd6, 32'h08);
        wb_read(3'd6, rd); check("w1c_plain", rd, 32'h0);

        // 6: reset during a pending write -> no ack, no commit
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 3'd0; wb_dat_i = 32'hFF;
        rst_in = 1'b0;
        @(negedge clk_i);
        check("rstb_ack", {31'h0, wb_ack_o}, 32'h0);
        check("rstb_out", {24'h0, gpio_o},   32'h0);
        check("rstb_oeb", {24'h0, gpio_oeb}, 32'h0000_00F0);
        check("rstb_dat", wb_dat_o,          32'h0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk_i);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_i);
        wb_read(3'd0, rd); check("rstb_rd_out", rd, 32'h0);
        wb_read(3'd3, rd); check("rstb_rd_ien", rd, 32'h0);
        repeat (2) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
